// File: rtl/scratchpad_if.sv
// rtl/scratchpad_if.sv - request/response channel bundle for the scratchpad controller
//
// Purpose: groups the valid/ready request channel and the valid/ready
// response channel between a core-side requester and scratchpad_ctrl.
// Ports (signals):
//   req_valid/req_ready            request handshake
//   req_write, req_addr, req_len,  request payload (store flag, absolute byte
//   req_wdata, req_id              address, size code, store data, tag)
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_id,           response payload (load data, tag echo,
//   resp_write, resp_err           store echo, reject flag)
// Modports: master = requester side, slave = scratchpad side.

interface scratchpad_if #(
  parameter int ID_WIDTH = 4
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [63:0]         req_addr;
  logic [1:0]          req_len;
  logic [63:0]         req_wdata;
  logic [ID_WIDTH-1:0] req_id;
  logic                resp_valid;
  logic                resp_ready;
  logic [63:0]         resp_rdata;
  logic [ID_WIDTH-1:0] resp_id;
  logic                resp_write;
  logic                resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, req_id, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_id, resp_write, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, req_id, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_id, resp_write, resp_err
  );
endinterface

// File: rtl/scratchpad_ctrl.sv
// rtl/scratchpad_ctrl.sv - byte-addressed scratchpad with tagged in-order responses
//
// Purpose: local memory of CHUNK_SIZE*NUM_CHUNKS bytes at SCRATCHPAD_BASE.
// Requests are decoded and executed at the accept edge; the result is queued
// in a RESP_DEPTH-entry response FIFO and handed out in acceptance order.
// Out-of-range, overrunning or misaligned requests are answered with
// resp_err = 1 and leave memory untouched.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (queue and counters only)
//   bus        scratchpad_if.slave request/response channels
//   err_count  saturating count of error responses

module scratchpad_ctrl #(
  parameter int          CHUNK_SIZE      = 512,
  parameter int          NUM_CHUNKS      = 1024,
  parameter logic [63:0] SCRATCHPAD_BASE = 64'h0300_0000_0000_0000,
  parameter int          ID_WIDTH        = 4,
  parameter int          RESP_DEPTH      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  scratchpad_if.slave  bus,
  output logic [15:0]  err_count
);
  localparam int          SIZE   = CHUNK_SIZE * NUM_CHUNKS;
  localparam logic [63:0] SIZE64 = 64'(SIZE);
  localparam int          AW     = $clog2(SIZE);
  localparam int          PW     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int          CW     = $clog2(RESP_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);

  logic [7:0] mem [SIZE];

  logic                accept;
  logic                pop;
  logic [63:0]         offset;
  logic [63:0]         size_b;
  logic [3:0]          nbytes;
  logic                dec_err;
  logic [AW-1:0]       idx;
  logic [63:0]         rd_data;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                req_ready_q;

  logic [63:0]         q_rdata [RESP_DEPTH];
  logic [ID_WIDTH-1:0] q_id    [RESP_DEPTH];
  logic                q_write [RESP_DEPTH];
  logic                q_err   [RESP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign accept = bus.req_valid && req_ready_q;
  assign pop    = bus.resp_valid && bus.resp_ready;

  // Addresses below the base wrap to a huge offset and fall out of range.
  assign offset  = bus.req_addr - SCRATCHPAD_BASE;
  assign size_b  = 64'd1 << bus.req_len;
  assign nbytes  = 4'd1 << bus.req_len;
  assign dec_err = (offset >= SIZE64) ||
                   ((offset + size_b) > SIZE64) ||
                   ((offset & (size_b - 64'd1)) != 64'd0);
  assign idx     = offset[AW-1:0];

  always_comb begin
    rd_data = '0;
    if (!dec_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) rd_data[8*i +: 8] = mem[idx + AW'(i)];
      end
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !dec_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[idx + AW'(i)] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (accept && !pop)      count_nxt = count + CW'(1);
    else if (!accept && pop) count_nxt = count - CW'(1);
  end

  // req_ready is computed from the next occupancy and registered, so a pop
  // only reopens the request channel on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      req_ready_q <= 1'b1;
      err_count   <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        q_rdata[i] <= '0;
        q_id[i]    <= '0;
        q_write[i] <= 1'b0;
        q_err[i]   <= 1'b0;
      end
    end else begin
      count       <= count_nxt;
      req_ready_q <= (count_nxt < CW'(RESP_DEPTH));
      if (accept) begin
        q_rdata[wr_ptr] <= bus.req_write ? 64'd0 : rd_data;
        q_id[wr_ptr]    <= bus.req_id;
        q_write[wr_ptr] <= bus.req_write;
        q_err[wr_ptr]   <= dec_err;
        wr_ptr          <= ptr_inc(wr_ptr);
        if (dec_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = (count != '0);
  assign bus.resp_rdata = q_rdata[rd_ptr];
  assign bus.resp_id    = q_id[rd_ptr];
  assign bus.resp_write = q_write[rd_ptr];
  assign bus.resp_err   = q_err[rd_ptr];
endmodule

// File: tb/tb_scratchpad_ctrl.sv
// tb/tb_scratchpad_ctrl.sv - self-checking bench for scratchpad_ctrl

module tb_scratchpad_ctrl;
  localparam int          ID_WIDTH = 4;
  localparam logic [63:0] BASE     = 64'h0300_0000_0000_0000;
  localparam logic [63:0] SIZE     = 64'h0008_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scratchpad_if #(.ID_WIDTH(ID_WIDTH)) bus();
  logic [15:0] err_count;

  scratchpad_ctrl #(
    .CHUNK_SIZE(512), .NUM_CHUNKS(1024), .SCRATCHPAD_BASE(BASE),
    .ID_WIDTH(ID_WIDTH), .RESP_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_count(err_count)
  );

  typedef struct {
    logic [63:0] rdata;
    logic [3:0]  id;
    logic        write;
    logic        err;
    int          at;
  } resp_t;

  typedef struct {
    logic        w;
    logic [63:0] off;
    logic [1:0]  len;
    logic [63:0] wd;
    logic [3:0]  id;
    logic        exp_err;
    logic [63:0] exp_rd;
    logic [15:0] exp_ec;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  logic rand_done = 1'b0;
  resp_t exp_q[$];
  resp_t obs_q[$];
  resp_t mon_o, mon_e;
  logic [7:0] ref_mem [bit [63:0]];
  logic [15:0] ref_errcnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flat byte map plus a queue of expected responses in accept order.
  task automatic model_accept();
    logic [63:0] off, sz;
    resp_t e;
    off = bus.req_addr - BASE;
    sz = 64'd1 << bus.req_len;
    e.id = bus.req_id;
    e.write = bus.req_write;
    e.rdata = 64'd0;
    e.at = 0;
    e.err = (off >= SIZE) || (off + sz > SIZE) || ((off % sz) != 64'd0);
    if (e.err) begin
      if (ref_errcnt != 16'hFFFF) ref_errcnt++;
    end else begin
      for (int b = 0; b < int'(sz); b++) begin
        if (bus.req_write) ref_mem[off + 64'(b)] = bus.req_wdata[8*b +: 8];
        else e.rdata[8*b +: 8] = ref_mem[off + 64'(b)];
      end
    end
    exp_q.push_back(e);
    n_acc++;
  endtask

  // Sampled at the falling edge: these values hold at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid && bus.resp_ready) begin
        mon_o.rdata = bus.resp_rdata;
        mon_o.id = bus.resp_id;
        mon_o.write = bus.resp_write;
        mon_o.err = bus.resp_err;
        mon_o.at = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got id %0d with nothing outstanding", mon_o.id);
        end else begin
          mon_e = exp_q.pop_front();
          check("model_rdata", mon_o.rdata, mon_e.rdata);
          check("model_id", 64'(mon_o.id), 64'(mon_e.id));
          check("model_flags", 64'({mon_o.write, mon_o.err}), 64'({mon_e.write, mon_e.err}));
        end
        obs_q.push_back(mon_o);
      end
      if (bus.req_valid && bus.req_ready) model_accept();
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic w, input logic [63:0] addr, input logic [1:0] len,
                      input logic [63:0] wd, input logic [3:0] id);
    int t;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr = addr;
    bus.req_len = len;
    bus.req_wdata = wd;
    bus.req_id = id;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 for id %0d", id);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (obs_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", obs_q.size(), n);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[12];
    resp_t o, o1;
    logic [63:0] dbl, off;
    int acc0, sel;

    vt[0]  = '{1'b1, 64'h10,      2'd3, 64'h1122_3344_5566_7788, 4'd3,  1'b0, 64'h0, 16'd0};
    vt[1]  = '{1'b0, 64'h10,      2'd3, 64'h0,                   4'd4,  1'b0, 64'h1122_3344_5566_7788, 16'd0};
    vt[2]  = '{1'b0, 64'h13,      2'd0, 64'h0,                   4'd5,  1'b0, 64'h55, 16'd0};
    vt[3]  = '{1'b0, 64'h16,      2'd1, 64'h0,                   4'd6,  1'b0, 64'h1122, 16'd0};
    vt[4]  = '{1'b0, 64'h2,       2'd2, 64'h0,                   4'd7,  1'b1, 64'h0, 16'd1};
    vt[5]  = '{1'b1, SIZE,        2'd0, 64'hEE,                  4'd8,  1'b1, 64'h0, 16'd2};
    vt[6]  = '{1'b0, -64'd8,      2'd3, 64'h0,                   4'd9,  1'b1, 64'h0, 16'd3};
    vt[7]  = '{1'b0, 64'h0,       2'd0, 64'h0,                   4'd10, 1'b0, 64'h5A, 16'd3};
    vt[8]  = '{1'b1, SIZE - 64'd8, 2'd3, 64'hA5A5_0F0F_C3C3_1234, 4'd11, 1'b0, 64'h0, 16'd3};
    vt[9]  = '{1'b0, SIZE - 64'd8, 2'd3, 64'h0,                  4'd12, 1'b0, 64'hA5A5_0F0F_C3C3_1234, 16'd3};
    vt[10] = '{1'b1, SIZE - 64'd1, 2'd1, 64'hBEEF,               4'd13, 1'b1, 64'h0, 16'd4};
    vt[11] = '{1'b0, SIZE - 64'd4, 2'd2, 64'h0,                  4'd14, 1'b0, 64'hA5A5_0F0F, 16'd4};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = 64'd0;
    bus.req_len = 2'd0;
    bus.req_wdata = 64'd0;
    bus.req_id = 4'd0;
    bus.resp_ready = 1'b1;

    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_flags", 64'({bus.resp_write, bus.resp_err}), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill the first 256 bytes with byte[a] = a ^ 8'h5A.
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 8; j++) dbl[8*j +: 8] = 8'(8*k + j) ^ 8'h5A;
      send(1'b1, BASE + 64'(8*k), 2'd3, dbl, 4'(k));
    end
    wait_obs(32);
    obs_q.delete();

    for (int i = 0; i < 12; i++) begin
      send(vt[i].w, BASE + vt[i].off, vt[i].len, vt[i].wd, vt[i].id);
      wait_obs(1);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check($sformatf("vec%0d_rdata", i), o.rdata, vt[i].exp_rd);
        check($sformatf("vec%0d_err", i), 64'(o.err), 64'(vt[i].exp_err));
        check($sformatf("vec%0d_id", i), 64'(o.id), 64'(vt[i].id));
        check($sformatf("vec%0d_write", i), 64'(o.write), 64'(vt[i].w));
      end
      check($sformatf("vec%0d_err_count", i), 64'(err_count), 64'(vt[i].exp_ec));
    end

    // Streaming: store at edge N, load of the same address at N+1.
    send(1'b1, BASE + 64'h40, 2'd3, 64'hDEAD_BEEF_0BAD_F00D, 4'd1);
    send(1'b0, BASE + 64'h40, 2'd3, 64'h0, 4'd2);
    wait_obs(2);
    if (obs_q.size() >= 2) begin
      o1 = obs_q.pop_front();
      o = obs_q.pop_front();
      check("stream_load_data", o.rdata, 64'hDEAD_BEEF_0BAD_F00D);
      check("stream_one_per_cycle", 64'(o.at), 64'(o1.at + 1));
    end
    obs_q.delete();

    // Back-pressure: four loads with resp_ready low.
    bus.resp_ready = 1'b0;
    acc0 = n_acc;
    send(1'b0, BASE + 64'h10, 2'd3, 64'h0, 4'd1);
    send(1'b0, BASE + 64'h13, 2'd0, 64'h0, 4'd2);
    @(negedge clk);
    check("bp_ready_low", 64'(bus.req_ready), 64'd0);
    check("bp_two_accepted", 64'(n_acc - acc0), 64'd2);
    @(posedge clk);
    #1;
    fork
      begin
        send(1'b0, BASE + 64'h16, 2'd1, 64'h0, 4'd3);
        send(1'b0, BASE + 64'h00, 2'd2, 64'h0, 4'd4);
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_still_blocked", 64'(bus.req_ready), 64'd0);
        check("bp_no_extra_accept", 64'(n_acc - acc0), 64'd2);
        check("bp_head_stable", 64'(bus.resp_id), 64'd1);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
      end
    join
    wait_obs(4);
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check($sformatf("bp_order%0d", i), 64'(o.id), 64'(i + 1));
      end
    end
    obs_q.delete();

    // Randomised traffic with random back-pressure, checked by the model.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          sel = $urandom_range(0, 9);
          if (sel < 8) begin
            if (sel < 4) off = 64'h80 + 64'($urandom_range(0, 127));
            else off = 64'($urandom_range(0, 255));
            send(sel < 4, BASE + off, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)));
          end else if (sel == 8) begin
            send(1'($urandom_range(0, 1)), BASE + SIZE + 64'($urandom_range(0, 300)),
                 2'($urandom_range(0, 3)), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
          end else begin
            send(1'($urandom_range(0, 1)), BASE - 64'($urandom_range(1, 64)),
                 2'($urandom_range(0, 3)), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.resp_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_err_count", 64'(err_count), 64'(ref_errcnt));
    obs_q.delete();

    // Reset with two responses queued.
    bus.resp_ready = 1'b0;
    send(1'b0, BASE + 64'h10, 2'd3, 64'h0, 4'd5);
    send(1'b0, BASE + 64'h18, 2'd3, 64'h0, 4'd6);
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.resp_valid), 64'd0);
    check("async_rst_ready", 64'(bus.req_ready), 64'd1);
    check("async_rst_err_count", 64'(err_count), 64'd0);
    check("async_rst_id", 64'(bus.resp_id), 64'd0);
    exp_q.delete();
    obs_q.delete();
    ref_errcnt = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, BASE + 64'h10, 2'd3, 64'h0, 4'd7);
    wait_obs(1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check("post_rst_mem_kept", o.rdata, 64'h1122_3344_5566_7788);
      check("post_rst_id", 64'(o.id), 64'd7);
    end
    check("post_rst_err_count", 64'(err_count), 64'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
